clk_monitor: RTL and testbench
==============================

Name: clk_monitor

Overview:
- Synthesizable checker for a clock that the design receives from an external generator or a clock-generation block.
- Samples the monitored clock with the system clock and measures its period and high time, both in sample counts.
- Flags frequency/duty violations, a stopped clock, and a locked condition.
- Sits beside clock sources as the measuring end of the clock-generation interface; results feed status registers and testbench checkers.

Parameters:
CNT_W, 16, width of period/high counters
SYNC_STAGES, 2, synchronizer depth for mon_clk (>=2)
EXP_PERIOD, 10, expected period in clk cycles
EXP_HIGH, 5, expected high time in clk cycles
TOL, 1, allowed +/- deviation for period and high time, in clk cycles
LOCK_CNT, 4, consecutive good periods required to assert locked
TIMEOUT, 1024, clk cycles without a rising edge before stopped is declared (must be < 2**CNT_W)

Ports:
clk  input  1  sampling clock; all logic is on its rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  monitor enable; level-sensitive
mon_clk  input  1  monitored clock, asynchronous to clk
period_cnt  output  CNT_W  last measured period, in clk cycles
high_cnt  output  CNT_W  last measured high time, in clk cycles
meas_valid  output  1  one-cycle pulse when period_cnt/high_cnt update
freq_ok  output  1  last period within EXP_PERIOD+/-TOL
duty_ok  output  1  last high time within EXP_HIGH+/-TOL
locked  output  1  LOCK_CNT consecutive periods with freq_ok and duty_ok
stopped  output  1  no rising edge for TIMEOUT cycles
err_cnt  output  8  saturating count of bad periods plus timeouts

Behaviour:
- Interface: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset: all outputs 0, state IDLE, synchronizer flops 0.
- Synchronizer and edge detect:
  - mon_clk passes through SYNC_STAGES flops to give s; s_prev is s delayed by one clk cycle.
  - rise = s & ~s_prev.
  - meas_valid is registered. It goes high on the clk edge that comes SYNC_STAGES edges after the edge that first samples mon_clk high.
- Counters:
  - run_cnt loads 1 on the rise cycle, then increments each cycle and saturates at all-ones.
  - hi_cnt loads 1 on the rise cycle, then increments each cycle in which s=1 and saturates.
- States:
  - IDLE: counters held. Goes to ARM when enable=1; err_cnt is cleared on that transition.
  - ARM: waiting for the first rise. On rise, start counters and go to MEASURE. If run_cnt reaches TIMEOUT, take the timeout action and stay in ARM.
  - MEASURE, on each rise:
    - period_cnt <= run_cnt, high_cnt <= hi_cnt, meas_valid <= 1.
    - freq_ok and duty_ok are updated from the new values; counters restart.
    - stopped <= 0.
  - MEASURE, if run_cnt reaches TIMEOUT: take the timeout action and go to ARM.
- Timeout action: stopped <= 1, locked <= 0, freq_ok <= 0, good counter <= 0, err_cnt += 1.
- Good-period tracking:
  - A period is good if both of its checks pass. Each good period increments a good counter, which saturates at LOCK_CNT.
  - locked asserts on the same edge as the meas_valid that brings the good counter to LOCK_CNT.
  - A bad period clears locked and the good counter, and increments err_cnt.
- Tolerance checks: compare |measured - expected| <= TOL with unsigned-safe arithmetic; no wrap when measured < expected.
- Simultaneous events: if a rise and the TIMEOUT condition occur in the same cycle, the rise wins and no timeout is recorded.
- err_cnt saturates at 255.
- enable deasserted in any state: go to IDLE on the next edge.
  - meas_valid, locked, stopped, freq_ok, duty_ok <= 0.
  - period_cnt, high_cnt and err_cnt hold.
  - A measurement in progress is discarded.
- rst_n asserted mid-operation: immediate return to reset values. The first measurement after reset needs two rising edges (one to arm, one to measure).
- mon_clk high time below 1 clk cycle may be missed; the period is then measured over the next detected rise. This is not flagged separately.

Test Plan:
- Defaults, clk 10 ns, mon_clk period 100 ns at 50% duty, enable=1 -> every meas_valid gives period_cnt=10, high_cnt=5, freq_ok=duty_ok=1; locked=1 on the 4th meas_valid; err_cnt=0.
- mon_clk 100 ns period at 30% duty -> high_cnt=3, duty_ok=0, locked stays 0, err_cnt increments each period.
- Locked, then mon_clk period changes to 130 ns -> period_cnt=13, freq_ok=0, locked drops that cycle, err_cnt=1; back at 100 ns -> locked again after 4 good periods.
- Locked, then mon_clk held low -> stopped=1 exactly 1024 cycles after the last rise, locked=0, err_cnt+1; mon_clk restarts -> stopped clears at the first meas_valid.
- enable dropped mid-period, then re-raised -> no meas_valid while low, status flags 0, period_cnt holds its last value, err_cnt=0 after re-enable, first meas_valid after two rises.
- rst_n pulsed low asynchronously between clk edges while locked -> all outputs 0 immediately; normal operation resumes after release.

Source files
------------

// File: rtl/clk_monitor.sv
// clk_monitor: measures the period and high time of an asynchronous clock
// in clk cycles, checks both against expected values within a tolerance,
// and reports lock, stop and error status.
`timescale 1ns/1ps
module clk_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EXP_PERIOD  = 10,
  parameter int EXP_HIGH    = 5,
  parameter int TOL         = 1,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mon_clk,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             freq_ok,
  output logic             duty_ok,
  output logic             locked,
  output logic             stopped,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0]  EXP_P_C   = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0]  EXP_H_C   = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0]  TOL_C     = CNT_W'(TOL);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE_C = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX_C = {CNT_W{1'b1}};
  localparam logic [GOOD_W-1:0] LOCK_C    = GOOD_W'(LOCK_CNT);
  localparam logic [GOOD_W-1:0] GOOD_ONE_C = GOOD_W'(1);

  // Absolute difference taken in the larger-minus-smaller order so an
  // undershoot never wraps to a huge unsigned value.
  function automatic logic in_tol(input logic [CNT_W-1:0] meas,
                                  input logic [CNT_W-1:0] expv);
    logic [CNT_W-1:0] diff;
    if (meas >= expv) begin
      diff = meas - expv;
    end else begin
      diff = expv - meas;
    end
    return (diff <= TOL_C);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX_C) begin
      return v;
    end else begin
      return v + CNT_ONE_C;
    end
  endfunction

  state_t                   state_r;
  logic [SYNC_STAGES-1:0]   sync_r;
  logic                     s_s;
  logic                     s_prev_r;
  logic [CNT_W-1:0]         run_cnt_r;
  logic [CNT_W-1:0]         hi_cnt_r;
  logic [GOOD_W-1:0]        good_cnt_r;

  logic                     rise_s;
  logic                     tmo_s;
  logic                     f_ok_s;
  logic                     d_ok_s;
  logic [CNT_W-1:0]         run_inc_s;
  logic [CNT_W-1:0]         hi_inc_s;
  logic [GOOD_W-1:0]        good_nxt_s;
  logic [7:0]               err_inc_s;

  assign s_s = sync_r[SYNC_STAGES-1];

  // Synchronize mon_clk into the clk domain and keep one cycle of history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r   <= '0;
      s_prev_r <= 1'b0;
    end else begin
      sync_r   <= {sync_r[SYNC_STAGES-2:0], mon_clk};
      s_prev_r <= s_s;
    end
  end

  // Edge detect, timeout detect, tolerance checks and saturating increments.
  always_comb begin
    rise_s     = s_s & ~s_prev_r;
    tmo_s      = (run_cnt_r == TIMEOUT_C);
    f_ok_s     = in_tol(run_cnt_r, EXP_P_C);
    d_ok_s     = in_tol(hi_cnt_r, EXP_H_C);
    run_inc_s  = sat_inc(run_cnt_r);
    hi_inc_s   = s_s ? sat_inc(hi_cnt_r) : hi_cnt_r;
    good_nxt_s = (good_cnt_r == LOCK_C) ? LOCK_C : (good_cnt_r + GOOD_ONE_C);
    err_inc_s  = (err_cnt == 8'hFF) ? err_cnt : (err_cnt + 8'd1);
  end

  // Monitor FSM: counters, measurement capture and all registered status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      run_cnt_r  <= '0;
      hi_cnt_r   <= '0;
      good_cnt_r <= '0;
      period_cnt <= '0;
      high_cnt   <= '0;
      meas_valid <= 1'b0;
      freq_ok    <= 1'b0;
      duty_ok    <= 1'b0;
      locked     <= 1'b0;
      stopped    <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      meas_valid <= 1'b0;
      if (!enable) begin
        // Disabling discards any measurement in progress; results and
        // err_cnt keep their last values for software to read.
        state_r    <= IDLE;
        good_cnt_r <= '0;
        freq_ok    <= 1'b0;
        duty_ok    <= 1'b0;
        locked     <= 1'b0;
        stopped    <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            state_r   <= ARM;
            err_cnt   <= 8'd0;
            run_cnt_r <= CNT_ONE_C;
            hi_cnt_r  <= '0;
          end
          ARM: begin
            if (rise_s) begin
              run_cnt_r <= CNT_ONE_C;
              hi_cnt_r  <= CNT_ONE_C;
              state_r   <= MEASURE;
            end else if (tmo_s) begin
              // Restart the count so a dead clock is re-reported every TIMEOUT.
              stopped    <= 1'b1;
              locked     <= 1'b0;
              freq_ok    <= 1'b0;
              good_cnt_r <= '0;
              err_cnt    <= err_inc_s;
              run_cnt_r  <= CNT_ONE_C;
            end else begin
              run_cnt_r <= run_inc_s;
            end
          end
          MEASURE: begin
            if (rise_s) begin
              period_cnt <= run_cnt_r;
              high_cnt   <= hi_cnt_r;
              meas_valid <= 1'b1;
              freq_ok    <= f_ok_s;
              duty_ok    <= d_ok_s;
              stopped    <= 1'b0;
              run_cnt_r  <= CNT_ONE_C;
              hi_cnt_r   <= CNT_ONE_C;
              if (f_ok_s && d_ok_s) begin
                good_cnt_r <= good_nxt_s;
                locked     <= (good_nxt_s == LOCK_C);
              end else begin
                good_cnt_r <= '0;
                locked     <= 1'b0;
                err_cnt    <= err_inc_s;
              end
            end else if (tmo_s) begin
              stopped    <= 1'b1;
              locked     <= 1'b0;
              freq_ok    <= 1'b0;
              good_cnt_r <= '0;
              err_cnt    <= err_inc_s;
              run_cnt_r  <= CNT_ONE_C;
              state_r    <= ARM;
            end else begin
              run_cnt_r <= run_inc_s;
              hi_cnt_r  <= hi_inc_s;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_monitor.sv
// tb_clk_monitor: directed scenarios for clk_monitor with hand-computed
// expectations. clk posedges fall at 5 mod 10 ns, mon_clk edges at 2 mod 10 ns.
`timescale 1ns/1ps
module tb_clk_monitor;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        mon_clk;
  logic [15:0] period_cnt;
  logic [15:0] high_cnt;
  logic        meas_valid;
  logic        freq_ok;
  logic        duty_ok;
  logic        locked;
  logic        stopped;
  logic [7:0]  err_cnt;

  int  pass_cnt = 0;
  int  chk_cnt  = 0;
  int  mon_period = 100;
  int  mon_high   = 50;
  bit  mon_run    = 1'b0;
  int  mon_rises  = 0;

  // Status bundle: {meas_valid, period, high, freq_ok, duty_ok, locked, stopped, err_cnt}
  logic [44:0] st;
  assign st = {meas_valid, period_cnt, high_cnt, freq_ok, duty_ok, locked, stopped, err_cnt};

  clk_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .mon_clk    (mon_clk),
    .period_cnt (period_cnt),
    .high_cnt   (high_cnt),
    .meas_valid (meas_valid),
    .freq_ok    (freq_ok),
    .duty_ok    (duty_ok),
    .locked     (locked),
    .stopped    (stopped),
    .err_cnt    (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitored clock: period and high time latched at the start of each cycle.
  initial begin
    int p;
    int h;
    mon_clk = 1'b0;
    #2;
    forever begin
      if (mon_run) begin
        p = mon_period;
        h = mon_high;
        mon_clk = 1'b1;
        #(h);
        mon_clk = 1'b0;
        #(p - h);
      end else begin
        #10;
      end
    end
  end

  always @(posedge mon_clk) mon_rises++;

  task automatic wait_meas(output bit got);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (meas_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [44:0] exp_v;
    rst_n = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    exp_v = 45'd0;
    chk_cnt++;
    if (st !== exp_v) $display("FAIL reset_hold: st=%h expected %h", st, exp_v);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (st !== exp_v) $display("FAIL reset_idle: st=%h expected %h", st, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_nominal();
    logic [44:0] exp_v;
    bit got;
    enable = 1'b1;
    @(negedge clk);
    mon_period = 100;
    mon_high = 50;
    mon_run = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      wait_meas(got);
      exp_v = {1'b1, 16'd10, 16'd5, 1'b1, 1'b1, (i >= 4), 1'b0, 8'd0};
      chk_cnt++;
      if ({got, st} !== {1'b1, exp_v})
        $display("FAIL nominal_%0d: got=%b st=%h expected %h", i, got, st, exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_period_change();
    logic [44:0] exp_v;
    bit got;
    mon_period = 130;
    wait_meas(got);
    wait_meas(got);
    exp_v = {1'b1, 16'd13, 16'd5, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
    chk_cnt++;
    if ({got, st} !== {1'b1, exp_v})
      $display("FAIL period_130: got=%b st=%h expected %h", got, st, exp_v);
    else pass_cnt++;
    mon_period = 100;
    wait_meas(got);
    for (int i = 1; i <= 4; i++) begin
      wait_meas(got);
      exp_v = {1'b1, 16'd10, 16'd5, 1'b1, 1'b1, (i == 4), 1'b0, 8'd2};
      chk_cnt++;
      if ({got, st} !== {1'b1, exp_v})
        $display("FAIL relock_%0d: got=%b st=%h expected %h", i, got, st, exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_stop();
    logic [44:0] exp_v;
    bit got;
    mon_run = 1'b0;
    repeat (1023) @(negedge clk);
    exp_v = {1'b0, 16'd10, 16'd5, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2};
    chk_cnt++;
    if (st !== exp_v) $display("FAIL stop_before: st=%h expected %h", st, exp_v);
    else pass_cnt++;
    @(negedge clk);
    exp_v = {1'b0, 16'd10, 16'd5, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3};
    chk_cnt++;
    if (st !== exp_v) $display("FAIL stop_at_timeout: st=%h expected %h", st, exp_v);
    else pass_cnt++;
    mon_run = 1'b1;
    wait_meas(got);
    exp_v = {1'b1, 16'd10, 16'd5, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3};
    chk_cnt++;
    if ({got, st} !== {1'b1, exp_v})
      $display("FAIL stop_restart: got=%b st=%h expected %h", got, st, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_duty();
    logic [44:0] exp_v;
    bit got;
    mon_high = 30;
    wait_meas(got);
    for (int i = 1; i <= 2; i++) begin
      wait_meas(got);
      exp_v = {1'b1, 16'd10, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'(3 + i)};
      chk_cnt++;
      if ({got, st} !== {1'b1, exp_v})
        $display("FAIL duty30_%0d: got=%b st=%h expected %h", i, got, st, exp_v);
      else pass_cnt++;
    end
    mon_high = 50;
  endtask

  task automatic test_enable();
    logic [44:0] exp_v;
    bit got;
    int seen;
    int base;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    exp_v = {1'b0, 16'd10, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5};
    chk_cnt++;
    if (st !== exp_v) $display("FAIL disable_status: st=%h expected %h", st, exp_v);
    else pass_cnt++;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (meas_valid !== 1'b0) seen++;
    end
    chk_cnt++;
    if (seen !== 0) $display("FAIL disable_no_meas: saw %0d pulses, expected 0", seen);
    else pass_cnt++;
    @(posedge mon_clk);
    repeat (3) @(negedge clk);
    base = mon_rises;
    enable = 1'b1;
    @(negedge clk);
    exp_v = {1'b0, 16'd10, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    chk_cnt++;
    if (st !== exp_v) $display("FAIL reenable_clear: st=%h expected %h", st, exp_v);
    else pass_cnt++;
    wait_meas(got);
    exp_v = {1'b1, 16'd10, 16'd5, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    chk_cnt++;
    if ({got, st} !== {1'b1, exp_v})
      $display("FAIL reenable_meas: got=%b st=%h expected %h", got, st, exp_v);
    else pass_cnt++;
    chk_cnt++;
    if ((mon_rises - base) !== 2)
      $display("FAIL reenable_rises: got %0d rises, expected 2", mon_rises - base);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [44:0] exp_v;
    bit got;
    for (int i = 2; i <= 4; i++) begin
      wait_meas(got);
      exp_v = {1'b1, 16'd10, 16'd5, 1'b1, 1'b1, (i == 4), 1'b0, 8'd0};
      chk_cnt++;
      if ({got, st} !== {1'b1, exp_v})
        $display("FAIL prereset_%0d: got=%b st=%h expected %h", i, got, st, exp_v);
      else pass_cnt++;
    end
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_v = 45'd0;
    chk_cnt++;
    if (st !== exp_v) $display("FAIL async_reset: st=%h expected %h", st, exp_v);
    else pass_cnt++;
    #3;
    rst_n = 1'b1;
    wait_meas(got);
    exp_v = {1'b1, 16'd10, 16'd5, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    chk_cnt++;
    if ({got, st} !== {1'b1, exp_v})
      $display("FAIL post_reset: got=%b st=%h expected %h", got, st, exp_v);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_period_change();
    test_stop();
    test_duty();
    test_enable();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
